// File: rtl/jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_block_sequencer
// Description : Frame-level sequencer for the JPEG pipeline
//               (RGB2YCbCr -> FsDCT -> Quant -> Zigzag -> RLEncode).
//               Walks a frame one 8x8 block at a time:
//               load 64 pixels, pulse DCT start, wait for DCT result,
//               drain 64 coefficients.
//               All activity is qualified by enables and single-cycle
//               pulses on the one system clock.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_comp_en        - compress enable (high runs, low aborts)
//               i_conf_en        - latch i_conf_blocks (IDLE only)
//               i_conf_blocks    - blocks per frame
//               i_dct_done       - FsDCT result valid
//               i_out_ready      - RLEncode accepts a coefficient
//               o_read_en        - pixel load enable
//               o_addr_in        - source pixel address
//               o_pix_idx        - pixel index within block
//               o_dct_start      - 1-cycle DCT start pulse
//               o_enc_en         - zigzag/RLE advance (combinational)
//               o_enc_idx        - zigzag index being emitted
//               o_blk_cnt        - current block index
//               o_busy           - high whenever not IDLE
//               o_blk_done       - 1-cycle pulse per completed block
//               o_frame_done     - 1-cycle pulse with the last blk_done
//               o_err            - sticky DCT timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_block_sequencer #(
    parameter int NBLK_W      = 16,
    parameter int DCT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_comp_en,
    input  logic              i_conf_en,
    input  logic [NBLK_W-1:0] i_conf_blocks,
    input  logic              i_dct_done,
    input  logic              i_out_ready,
    output logic              o_read_en,
    output logic [31:0]       o_addr_in,
    output logic [5:0]        o_pix_idx,
    output logic              o_dct_start,
    output logic              o_enc_en,
    output logic [5:0]        o_enc_idx,
    output logic [NBLK_W-1:0] o_blk_cnt,
    output logic              o_busy,
    output logic              o_blk_done,
    output logic              o_frame_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_DCT_START = 3'd2,
        S_DCT_WAIT  = 3'd3,
        S_ENCODE    = 3'd4,
        S_BLK_END   = 3'd5
    } state_t;

    localparam logic [11:0]       c_TIMEOUT = 12'(DCT_TIMEOUT);
    localparam logic [NBLK_W-1:0] c_BLK_ONE = NBLK_W'(1);

    state_t              r_state;
    logic [NBLK_W-1:0]   r_nblocks;
    logic [NBLK_W-1:0]   r_blk_cnt;
    logic [5:0]          r_pix_idx;
    logic [5:0]          r_enc_idx;
    logic [11:0]         r_wait_cnt;
    logic [31:0]         r_addr;
    logic                r_read_en;
    logic                r_dct_start;
    logic                r_busy;
    logic                r_blk_done;
    logic                r_frame_done;
    logic                r_err;

    logic                w_enc_en;
    logic [5:0]          w_pix_inc;
    logic [NBLK_W-1:0]   w_blk_inc;
    logic                w_last_blk;
    logic [11:0]         w_wait_inc;
    logic [31:0]         w_blk_base;
    logic [31:0]         w_next_blk_base;

    assign w_enc_en        = (r_state == S_ENCODE) && i_out_ready;
    assign w_pix_inc       = r_pix_idx + 6'd1;
    assign w_blk_inc       = r_blk_cnt + c_BLK_ONE;
    assign w_last_blk      = (r_blk_cnt == (r_nblocks - c_BLK_ONE));
    assign w_wait_inc      = r_wait_cnt + 12'd1;
    assign w_blk_base      = 32'({r_blk_cnt, 6'b000000});
    assign w_next_blk_base = 32'({w_blk_inc, 6'b000000});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_nblocks    <= '0;
            r_blk_cnt    <= '0;
            r_pix_idx    <= '0;
            r_enc_idx    <= '0;
            r_wait_cnt   <= '0;
            r_addr       <= '0;
            r_read_en    <= 1'b0;
            r_dct_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_blk_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else if ((r_state != S_IDLE) && !i_comp_en) begin
            // Abort: drop straight back to IDLE without any done pulse;
            // the error flag keeps whatever it held.
            r_state      <= S_IDLE;
            r_blk_cnt    <= '0;
            r_pix_idx    <= '0;
            r_enc_idx    <= '0;
            r_wait_cnt   <= '0;
            r_addr       <= '0;
            r_read_en    <= 1'b0;
            r_dct_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_blk_done   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Pulse outputs default low; states that need them set them.
            r_dct_start  <= 1'b0;
            r_blk_done   <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Configuration takes priority over a start request.
                    if (i_conf_en) begin
                        r_nblocks <= i_conf_blocks;
                    end else if (i_comp_en && (r_nblocks != '0)) begin
                        r_state   <= S_READ;
                        r_blk_cnt <= '0;
                        r_pix_idx <= '0;
                        r_addr    <= '0;
                        r_read_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                    end
                end

                S_READ: begin
                    // Pixel index wraps to 0 naturally after 63; the address
                    // is kept equal to blk_cnt*64 + pix_idx at all times.
                    r_pix_idx <= w_pix_inc;
                    r_addr    <= w_blk_base + 32'(w_pix_inc);
                    if (r_pix_idx == 6'd63) begin
                        r_state     <= S_DCT_START;
                        r_read_en   <= 1'b0;
                        r_dct_start <= 1'b1;
                    end
                end

                S_DCT_START: begin
                    r_state    <= S_DCT_WAIT;
                    r_wait_cnt <= '0;
                end

                S_DCT_WAIT: begin
                    if (i_dct_done) begin
                        r_state   <= S_ENCODE;
                        r_enc_idx <= '0;
                    end else if (w_wait_inc == c_TIMEOUT) begin
                        // DCT never answered: flag it and abandon the frame.
                        r_state    <= S_IDLE;
                        r_err      <= 1'b1;
                        r_busy     <= 1'b0;
                        r_blk_cnt  <= '0;
                        r_pix_idx  <= '0;
                        r_addr     <= '0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end

                S_ENCODE: begin
                    // Downstream back-pressure may stall here indefinitely.
                    if (w_enc_en) begin
                        r_enc_idx <= r_enc_idx + 6'd1;
                        if (r_enc_idx == 6'd63) begin
                            r_state      <= S_BLK_END;
                            r_blk_done   <= 1'b1;
                            r_frame_done <= w_last_blk;
                        end
                    end
                end

                S_BLK_END: begin
                    if (w_last_blk) begin
                        r_state   <= S_IDLE;
                        r_blk_cnt <= '0;
                        r_addr    <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state   <= S_READ;
                        r_blk_cnt <= w_blk_inc;
                        r_addr    <= w_next_blk_base;
                        r_read_en <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_read_en    = r_read_en;
    assign o_addr_in    = r_addr;
    assign o_pix_idx    = r_pix_idx;
    assign o_dct_start  = r_dct_start;
    assign o_enc_en     = w_enc_en;
    assign o_enc_idx    = r_enc_idx;
    assign o_blk_cnt    = r_blk_cnt;
    assign o_busy       = r_busy;
    assign o_blk_done   = r_blk_done;
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_block_sequencer
// Description : Directed self-checking bench for jpeg_block_sequencer.
//               Inputs are driven on the falling edge, outputs sampled there.
//               A small DCT model answers each dct_start 8 cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_block_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        comp_en;
    logic        conf_en;
    logic [15:0] conf_blocks;
    logic        dct_done;
    logic        out_ready;

    logic        read_en;
    logic [31:0] addr_in;
    logic [5:0]  pix_idx;
    logic        dct_start;
    logic        enc_en;
    logic [5:0]  enc_idx;
    logic [15:0] blk_cnt;
    logic        busy;
    logic        blk_done;
    logic        frame_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    bit dct_auto = 1'b1;

    logic [66:0] w_all_out;
    assign w_all_out = {read_en, addr_in, pix_idx, dct_start, enc_en, enc_idx,
                        blk_cnt, busy, blk_done, frame_done, err};

    jpeg_block_sequencer #(
        .NBLK_W      (16),
        .DCT_TIMEOUT (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_comp_en     (comp_en),
        .i_conf_en     (conf_en),
        .i_conf_blocks (conf_blocks),
        .i_dct_done    (dct_done),
        .i_out_ready   (out_ready),
        .o_read_en     (read_en),
        .o_addr_in     (addr_in),
        .o_pix_idx     (pix_idx),
        .o_dct_start   (dct_start),
        .o_enc_en      (enc_en),
        .o_enc_idx     (enc_idx),
        .o_blk_cnt     (blk_cnt),
        .o_busy        (busy),
        .o_blk_done    (blk_done),
        .o_frame_done  (frame_done),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    // DCT model: result valid in the 8th cycle after the start pulse.
    initial begin : dct_model
        dct_done = 1'b0;
        forever begin
            @(negedge clk);
            if (dct_auto && dct_start) begin
                repeat (8) @(negedge clk);
                dct_done = 1'b1;
                @(negedge clk);
                dct_done = 1'b0;
            end
        end
    end

    task automatic configure(input int nblk);
        conf_blocks = 16'(nblk);
        conf_en     = 1'b1;
        @(negedge clk);
        conf_en     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (w_all_out !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", w_all_out);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %0b expected 0", busy);
        end
    endtask

    task automatic test_zero_blocks();
        int n_busy = 0;
        comp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || read_en) n_busy++;
        end
        comp_en = 1'b0;
        n_tests++;
        if (n_busy !== 0) begin
            n_fail++;
            $display("FAIL zero_blocks_busy: got %0d busy cycles expected 0", n_busy);
        end
    endtask

    task automatic test_frame_two_blocks();
        int n_read = 0, addr_err = 0, exp_addr = 0, last_addr = -1;
        int n_blk = 0, n_fd = 0, bd0 = -1, bd1 = -1, fd = -1, first_read = -1;
        bit done = 1'b0;
        out_ready = 1'b1;
        configure(2);
        comp_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (read_en) begin
                if (first_read < 0) first_read = i;
                if (addr_in !== 32'(exp_addr)) addr_err++;
                last_addr = int'(addr_in);
                exp_addr++;
                n_read++;
            end
            if (blk_done) begin
                if (n_blk == 0) bd0 = i; else bd1 = i;
                n_blk++;
            end
            if (frame_done) begin
                fd = i;
                n_fd++;
                comp_en = 1'b0;
                done = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done expected one within 600 cycles");
        end
        n_tests++;
        if (n_blk !== 2) begin
            n_fail++;
            $display("FAIL frame_blk_done_count: got %0d expected 2", n_blk);
        end
        n_tests++;
        if (bd0 - first_read !== 137) begin
            n_fail++;
            $display("FAIL first_block_latency: got %0d expected 137", bd0 - first_read);
        end
        n_tests++;
        if (bd1 - bd0 !== 138) begin
            n_fail++;
            $display("FAIL blk_done_spacing: got %0d expected 138", bd1 - bd0);
        end
        n_tests++;
        if (fd !== bd1) begin
            n_fail++;
            $display("FAIL frame_done_cycle: got %0d expected %0d", fd, bd1);
        end
        n_tests++;
        if (n_read !== 128 || addr_err !== 0 || last_addr !== 127) begin
            n_fail++;
            $display("FAIL addr_sweep: got reads=%0d errs=%0d last=%0d expected 128/0/127",
                     n_read, addr_err, last_addr);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || blk_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_end_idle: got busy=%0b blk_cnt=%0d expected 0/0", busy, blk_cnt);
        end
    endtask

    task automatic test_simultaneous_and_stall();
        int n_en = 0, seq_err = 0, exp_idx = 0, n_fd = 0, n_bd = 0;
        bit tog = 1'b1;
        bit done = 1'b0;
        // Config and start together: config wins, start happens next cycle.
        conf_blocks = 16'd1;
        conf_en     = 1'b1;
        comp_en     = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || read_en !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_no_start: got busy=%0b read_en=%0b expected 0/0", busy, read_en);
        end
        conf_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || read_en !== 1'b1 || addr_in !== 32'd0) begin
            n_fail++;
            $display("FAIL simul_start_next: got busy=%0b read_en=%0b addr=%0d expected 1/1/0",
                     busy, read_en, addr_in);
        end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            out_ready = tog;
            tog = ~tog;
            #1;
            if (enc_en) begin
                if (enc_idx !== 6'(exp_idx)) seq_err++;
                exp_idx++;
                n_en++;
            end
            if (blk_done) n_bd++;
            if (frame_done) begin
                n_fd++;
                comp_en = 1'b0;
                done = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL stall_timeout: got no frame_done expected one within 1000 cycles");
        end
        n_tests++;
        if (n_en !== 64) begin
            n_fail++;
            $display("FAIL stall_enc_en_count: got %0d expected 64", n_en);
        end
        n_tests++;
        if (seq_err !== 0) begin
            n_fail++;
            $display("FAIL stall_enc_idx_seq: got %0d errors expected 0", seq_err);
        end
        n_tests++;
        if (n_bd !== 1 || n_fd !== 1) begin
            n_fail++;
            $display("FAIL one_block_frame: got blk_done=%0d frame_done=%0d expected 1/1", n_bd, n_fd);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int ds = -1, ei = -1, n_bd = 0;
        bit busy_at = 1'b1;
        dct_auto = 1'b0;
        comp_en  = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (dct_start) ds = i;
            if (blk_done) n_bd++;
            if (err) begin
                ei = i;
                busy_at = busy;
                comp_en = 1'b0;
                break;
            end
        end
        n_tests++;
        if (ei < 0 || ds < 0 || ei - ds !== 256) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected 256 (start=%0d err=%0d)", ei - ds, ds, ei);
        end
        n_tests++;
        if (busy_at !== 1'b0 || n_bd !== 0) begin
            n_fail++;
            $display("FAIL timeout_idle: got busy=%0b blk_done=%0d expected 0/0", busy_at, n_bd);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %0b expected 1", err);
        end
        dct_auto = 1'b1;
    endtask

    task automatic test_abort();
        int n_bd = 0, n_fd = 0;
        bit hit = 1'b0;
        configure(2);
        comp_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_clears_err: got err=%0b busy=%0b expected 0/1", err, busy);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (blk_done) n_bd++;
            if (frame_done) n_fd++;
            if (read_en && blk_cnt == 16'd1 && pix_idx == 6'd30) begin
                comp_en = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL abort_point: got no block1 pix30 expected it within 400 cycles");
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || read_en !== 1'b0 || blk_cnt !== 16'd0 || pix_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%0b read_en=%0b blk=%0d pix=%0d expected 0/0/0/0",
                     busy, read_en, blk_cnt, pix_idx);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (blk_done) n_bd++;
            if (frame_done) n_fd++;
        end
        n_tests++;
        if (n_fd !== 0 || n_bd !== 1) begin
            n_fail++;
            $display("FAIL abort_pulses: got frame_done=%0d blk_done=%0d expected 0/1", n_fd, n_bd);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n_bd = 0, n_fd = 0, fd = -1;
        bit hit = 1'b0;
        comp_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (enc_en && enc_idx == 6'd10) begin
                hit = 1'b1;
                break;
            end
        end
        rst     = 1'b1;
        comp_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (!hit || w_all_out !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got hit=%0b outs=%h expected 1/0", hit, w_all_out);
        end
        rst = 1'b0;
        @(negedge clk);
        configure(1);
        comp_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            // Mid-frame reconfiguration must not change the frame length.
            conf_en = (i == 20);
            conf_blocks = 16'd5;
            if (blk_done) n_bd++;
            if (frame_done) begin
                n_fd++;
                fd = i;
                comp_en = 1'b0;
                break;
            end
        end
        conf_en = 1'b0;
        n_tests++;
        if (n_bd !== 1 || n_fd !== 1) begin
            n_fail++;
            $display("FAIL fresh_frame_pulses: got blk_done=%0d frame_done=%0d expected 1/1", n_bd, n_fd);
        end
        n_tests++;
        if (fd !== 137) begin
            n_fail++;
            $display("FAIL fresh_frame_timing: got %0d expected 137", fd);
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst         = 1'b1;
        comp_en     = 1'b0;
        conf_en     = 1'b0;
        conf_blocks = 16'd0;
        out_ready   = 1'b1;
        test_reset();
        test_zero_blocks();
        test_frame_two_blocks();
        test_simultaneous_and_stall();
        test_timeout();
        test_abort();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
